// File: rtl/arith_scheduler_if.sv
// Handshake bundle for arith_scheduler: two operand requesters and one result consumer.
interface arith_scheduler_if #(
    parameter int WIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic [1:0]           req0_op;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic [1:0]           req1_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [2*WIDTH-1:0]   rsp_result;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/arith_scheduler.sv
// Two-requester round-robin arithmetic unit: add, subtract and iterative shift-add multiply.
// The multiplier exists only when ARITH_SCHED_MUL_EN is defined; otherwise opcode 10 acts as reserved.
module arith_scheduler #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    arith_scheduler_if.slave bus
);
    localparam int         RW     = 2 * WIDTH;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             ptr_r;
    logic             id_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [RW-1:0]    rsp_result_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             ready0_s;
    logic             ready1_s;
    logic             accept_s;
    logic             exec_done_s;
    logic [1:0]       op_sel_s;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] b_sel_s;

`ifdef ARITH_SCHED_MUL_EN
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam int         CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [RW-1:0]    acc_r;
    logic [RW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CNT_W-1:0] cnt_r;
    logic [RW-1:0]    acc_sum_s;
    logic             is_mul_s;

    assign is_mul_s  = (op_r == OP_MUL);
    assign acc_sum_s = acc_r + (mplier_r[0] ? mcand_r : {RW{1'b0}});
`endif

    function automatic logic [RW-1:0] alu_result(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        case (op)
            OP_ADD:  alu_result = ax + bx;
            OP_SUB:  alu_result = ax - bx;
            default: alu_result = {RW{1'b0}};
        endcase
    endfunction

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;

    // Grant arbitration, ready generation and next-state logic.
    always_comb begin
        grant0_s     = 1'b0;
        grant1_s     = 1'b0;
        state_next_s = state_r;
        exec_done_s  = 1'b1;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = ~ptr_r;
            grant1_s = ptr_r;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
        ready0_s = (state_r == IDLE) && !rst && grant0_s;
        ready1_s = (state_r == IDLE) && !rst && grant1_s;
        accept_s = (bus.req0_valid && ready0_s) || (bus.req1_valid && ready1_s);
        op_sel_s = grant1_s ? bus.req1_op : bus.req0_op;
        a_sel_s  = grant1_s ? bus.req1_a  : bus.req0_a;
        b_sel_s  = grant1_s ? bus.req1_b  : bus.req0_b;
`ifdef ARITH_SCHED_MUL_EN
        if (is_mul_s) begin
            exec_done_s = (cnt_r == CNT_LAST);
        end else begin
            exec_done_s = 1'b1;
        end
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = EXEC;
                else          state_next_s = IDLE;
            end
            EXEC: begin
                if (exec_done_s) state_next_s = RESP;
                else             state_next_s = EXEC;
            end
            RESP: begin
                if (bus.rsp_ready) state_next_s = IDLE;
                else               state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Operand capture, multiply iteration and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r        <= 1'b0;
            id_r         <= 1'b0;
            op_r         <= 2'b00;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= {RW{1'b0}};
`ifdef ARITH_SCHED_MUL_EN
            acc_r        <= {RW{1'b0}};
            mcand_r      <= {RW{1'b0}};
            mplier_r     <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        id_r  <= grant1_s;
                        ptr_r <= ~grant1_s;
                        op_r  <= op_sel_s;
                        a_r   <= a_sel_s;
                        b_r   <= b_sel_s;
`ifdef ARITH_SCHED_MUL_EN
                        acc_r    <= {RW{1'b0}};
                        mcand_r  <= {{WIDTH{1'b0}}, a_sel_s};
                        mplier_r <= b_sel_s;
                        cnt_r    <= {CNT_W{1'b0}};
`endif
                    end
                end
                EXEC: begin
                    if (exec_done_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
`ifdef ARITH_SCHED_MUL_EN
                        // The last partial product is folded straight into the result.
                        rsp_result_r <= is_mul_s ? acc_sum_s : alu_result(op_r, a_r, b_r);
`else
                        rsp_result_r <= alu_result(op_r, a_r, b_r);
`endif
                    end
`ifdef ARITH_SCHED_MUL_EN
                    else begin
                        acc_r    <= acc_sum_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + CNT_ONE;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) rsp_valid_r <= 1'b0;
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_scheduler.sv
// Directed self-checking bench for arith_scheduler (WIDTH=8); expectations follow ARITH_SCHED_MUL_EN.
module tb_arith_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef ARITH_SCHED_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    localparam int MUL_LAT = MUL_ON ? 8 : 1;
    localparam int RST_DLY = MUL_ON ? 2 : 0;

    arith_scheduler_if #(.WIDTH(8)) bus ();
    arith_scheduler #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // One isolated operation with rsp_ready high: checks grant, latency, result and id.
    task automatic run_op(input string tag, input logic id, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_res, input int exp_lat);
        int n;
        set_req(id, 1'b1, op, a, b);
        #1;
        n = 0;
        while (((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        check_value({tag, "_ready"}, {31'd0, (id ? bus.req1_ready : bus.req0_ready)}, 32'd1);
        tick();
        set_req(id, 1'b0, 2'b00, 8'd0, 8'd0);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_value({tag, "_lat"}, n, exp_lat);
        check_value({tag, "_res"}, {16'd0, bus.rsp_result}, {16'd0, exp_res});
        check_value({tag, "_id"}, {31'd0, bus.rsp_id}, {31'd0, id});
        tick();
        check_value({tag, "_done"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic exp_id;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 2'b00, 8'd1, 8'd1);
        set_req(1'b1, 1'b1, 2'b00, 8'd1, 8'd1);
        tick();
        tick();
        check_value("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        check_value("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        check_value("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_value("rst_id", {31'd0, bus.rsp_id}, 32'd0);
        check_value("rst_result", {16'd0, bus.rsp_result}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 2'b00, 8'd0, 8'd0);
        rst = 1'b0;
        tick();

        run_op("add", 1'b0, 2'b00, 8'd200, 8'd100, 16'h012C, 1);
        run_op("sub", 1'b1, 2'b01, 8'd5, 8'd7, 16'hFFFE, 1);
        run_op("mul_ff", 1'b0, 2'b10, 8'd255, 8'd255, MUL_ON ? 16'hFE01 : 16'h0000, MUL_LAT);
        run_op("mul_small", 1'b1, 2'b10, 8'd13, 8'd11, MUL_ON ? 16'h008F : 16'h0000, MUL_LAT);
        run_op("rsvd", 1'b0, 2'b11, 8'd9, 8'd3, 16'h0000, 1);
        run_op("add_carry", 1'b1, 2'b00, 8'd255, 8'd255, 16'h01FE, 1);

        // Continuous dual requests after reset: grants alternate starting at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 2'b00, 8'd1, 8'd2);
        set_req(1'b1, 1'b1, 2'b01, 8'd9, 8'd4);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2) != 0;
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
                tick();
                n++;
            end
            check_value("alt_one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
            check_value("alt_grant", {31'd0, bus.req1_ready}, {31'd0, exp_id});
            tick();
            n = 0;
            while (bus.rsp_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check_value("alt_rsp_id", {31'd0, bus.rsp_id}, {31'd0, exp_id});
            check_value("alt_res", {16'd0, bus.rsp_result}, exp_id ? 32'd5 : 32'd3);
            check_value("alt_resp_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            tick();
        end
        set_req(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 2'b00, 8'd0, 8'd0);
        tick();

        // Back-pressure: response must hold for five stalled cycles.
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 2'b00, 8'd10, 8'd20);
        #1;
        check_value("bp_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        set_req(1'b1, 1'b1, 2'b01, 8'd9, 8'd4);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check_value("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check_value("bp_res", {16'd0, bus.rsp_result}, 32'd30);
            check_value("bp_id", {31'd0, bus.rsp_id}, 32'd0);
            check_value("bp_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_value("bp_valid6", {31'd0, bus.rsp_valid}, 32'd1);
        tick();
        check_value("bp_released", {31'd0, bus.rsp_valid}, 32'd0);
        check_value("bp_idle_ready1", {31'd0, bus.req1_ready}, 32'd1);
        set_req(1'b1, 1'b0, 2'b00, 8'd0, 8'd0);
        tick();
        // A dropped valid must leave the pointer on requester 1.
        set_req(1'b0, 1'b1, 2'b00, 8'd1, 8'd1);
        set_req(1'b1, 1'b1, 2'b00, 8'd1, 8'd1);
        #1;
        check_value("drop_ptr_r1", {31'd0, bus.req1_ready}, 32'd1);
        check_value("drop_ptr_r0", {31'd0, bus.req0_ready}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 2'b00, 8'd0, 8'd0);
        tick();

        // Reset during an in-flight multiply: no response, pointer back to 0.
        set_req(1'b0, 1'b1, 2'b10, 8'd255, 8'd255);
        #1;
        check_value("abort_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        seen = 0;
        for (int i = 0; i < RST_DLY; i++) begin
            if (bus.rsp_valid === 1'b1) seen++;
            tick();
        end
        if (bus.rsp_valid === 1'b1) seen++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("abort_result", {16'd0, bus.rsp_result}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid === 1'b1) seen++;
            tick();
        end
        check_value("abort_no_rsp", seen, 32'd0);
        set_req(1'b0, 1'b1, 2'b00, 8'd1, 8'd1);
        set_req(1'b1, 1'b1, 2'b00, 8'd1, 8'd1);
        #1;
        check_value("abort_grant0", {31'd0, bus.req0_ready}, 32'd1);
        check_value("abort_grant1", {31'd0, bus.req1_ready}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 2'b00, 8'd0, 8'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arith_scheduler.md
ARITH_SCHEDULER -- requirements
Module: arith_scheduler

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; result width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  scheduler accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  WIDTH each  requester N operands.
REQ-007 reqN_op  input  2  requester N opcode: 00 add, 01 subtract, 10 multiply, 11 reserved.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  index of the requester that issued the result.
REQ-011 rsp_result  output  2*WIDTH  operation result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-013 reqN_ready SHALL be high only in IDLE, for at most one N, and only when that N is granted.
REQ-014 Grant rule: if only one valid is high, grant that requester; if both are high, grant the requester holding the priority pointer.
REQ-015 On an accept (reqN_valid & reqN_ready), the operands, opcode and id SHALL be latched, the pointer SHALL move to the other requester, and the FSM SHALL go to EXEC.
REQ-016 Add SHALL produce the zero-extended sum, so the carry appears at bit WIDTH.
REQ-017 Subtract SHALL produce (a - b) mod 2^(2*WIDTH); for example 5-7 gives all-ones except bit 0.
REQ-018 Multiply SHALL use an iterative shift-add that takes exactly WIDTH EXEC cycles and produces the full 2*WIDTH-bit product.
REQ-019 Add, subtract and reserved SHALL spend exactly one cycle in EXEC; reserved SHALL produce a result of zero.
REQ-020 Latency: with the accept at edge k, rsp_valid SHALL be high after edge k+1 for single-cycle ops and after edge k+WIDTH for multiply.
REQ-021 In RESP, rsp_valid SHALL be high, and rsp_result and rsp_id SHALL hold stable until rsp_valid & rsp_ready.
REQ-022 On the response handshake the FSM SHALL return to IDLE; the earliest next accept is the following cycle.
REQ-023 Outside RESP, rsp_valid SHALL be low; outside IDLE, both reqN_ready SHALL be low.
REQ-024 A requester SHALL NOT be starved: under continuous dual requests, grants SHALL strictly alternate.
REQ-025 A valid dropped before its accept SHALL be ignored without changing the pointer.

Reset
REQ-026 On rst high at an edge the FSM SHALL go to IDLE, the priority pointer SHALL go to requester 0, and rsp_valid, rsp_id and rsp_result SHALL go to 0.
REQ-027 Reset SHALL take precedence over every handshake and abort any in-flight operation, including a multiply mid-iteration, with no result emitted.
REQ-028 While rst is high, both reqN_ready SHALL be low.

Configuration
REQ-029 Macro ARITH_SCHED_MUL_EN SHALL control the multiplier.
REQ-030 With ARITH_SCHED_MUL_EN defined, opcode 10 SHALL execute the iterative multiply per REQ-018.
REQ-031 Without ARITH_SCHED_MUL_EN, no multiplier logic SHALL exist, and opcode 10 SHALL behave as reserved: a one-cycle EXEC with a zero result.

Verification (WIDTH=8)
REQ-032 After reset, req0 only: add a=200, b=100 -> rsp_result=0x012C, rsp_id=0, rsp_valid one cycle after the accept.
REQ-033 req1 only: subtract a=5, b=7 -> rsp_result=0xFFFE, rsp_id=1.
REQ-034 Multiply a=255, b=255: with the macro -> 0xFE01 with rsp_valid 8 cycles after the accept; without the macro -> 0x0000 one cycle after the accept.
REQ-035 Both requesters valid continuously with rsp_ready=1 -> the grant sequence is 0,1,0,1 and rsp_id follows the same sequence.
REQ-036 rsp_ready held low for 5 cycles in RESP -> rsp_result and rsp_id stable, both reqN_ready low; the 6th cycle handshakes and the FSM returns to IDLE.
REQ-037 rst pulsed at EXEC cycle 3 of a multiply -> no rsp_valid is emitted, and the next simultaneous request grants requester 0.
